// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, arbitration-type encodings and grant helper for the 4-way arbiter subsystem
package arb_pkg;
    localparam int NUM_REQ        = 4;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        ARB_P0   = 3'd0,
        ARB_P1   = 3'd1,
        ARB_P2   = 3'd2,
        ARB_P3   = 3'd3,
        ARB_RR   = 3'd4,
        ARB_RAND = 3'd5
    } arb_type_e;

    function automatic logic [NUM_REQ-1:0] onehot_gnt(input logic [$clog2(NUM_REQ)-1:0] idx);
        logic [NUM_REQ-1:0] g;
        g      = '0;
        g[idx] = 1'b1;
        return g;
    endfunction
endpackage

// File: rtl/arb_req_fifo.sv
// arb_req_fifo: synchronous FIFO with combinational head read and occupancy count
module arb_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

    // next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = (do_push && !do_pop) ? level_q + LW'(1) :
                   (do_pop && !do_push) ? level_q - LW'(1) : level_q;
    end

    // pointer and occupancy state; reset discards any buffered words
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // storage array; contents are meaningless until written so it has no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/arb_requester.sv
// arb_requester: client side of the arbiter req/gnt interface; FIFO-buffered words, one bus word per grant.
// Optional starvation monitor enabled by defining ARB_REQ_STARVE_MON_EN (adds the starve output).
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       req,
    input  logic                       gnt,
    output logic                       bus_valid,
    output logic [DATA_W-1:0]          bus_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err_spurious
`ifdef ARB_REQ_STARVE_MON_EN
   ,output logic                       starve
`endif
);
    localparam int LW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 2) begin : g_bad_params
        $error("arb_requester: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 2");
    end

    logic [DATA_W-1:0] head;
    logic [LW-1:0]     lvl;
    logic              full, empty, push, pop;
    logic              bus_valid_q, bus_valid_d, err_q, err_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;

    arb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .level (lvl),
        .full  (full),
        .empty (empty)
    );

    // request drops while the last word is being granted so no stale request follows the final pop
    always_comb begin
        in_ready    = !full;
        push        = in_valid && in_ready;
        pop         = gnt && !empty;
        req         = (lvl > LW'(1)) || (lvl == LW'(1) && !gnt);
        bus_valid_d = pop;
        bus_data_d  = pop ? head : bus_data_q;
        err_d       = err_q || (gnt && empty);
    end

    // bus register and sticky spurious-grant flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            err_q       <= err_d;
        end
    end

    assign bus_valid    = bus_valid_q;
    assign bus_data     = bus_data_q;
    assign level        = lvl;
    assign err_spurious = err_q;

`ifdef ARB_REQ_STARVE_MON_EN
    localparam int CW = $clog2(STARVE_LIMIT+1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          starve_q, starve_d;

    // count consecutive denied request cycles, saturating; any grant or idle cycle restarts the count
    always_comb begin
        cnt_d    = (gnt || !req) ? '0 :
                   (cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + CW'(1);
        starve_d = cnt_d == CW'(STARVE_LIMIT);
    end

    // starvation counter and registered flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`endif
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed table-driven bench for arb_requester plus a four-port fixed-priority system check
module tb_arb_requester;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst, in_valid, gnt;
    logic [7:0] in_data;
    logic       in_ready, req, bus_valid, err_spurious;
    logic [7:0] bus_data;
    logic [2:0] level;
`ifdef ARB_REQ_STARVE_MON_EN
    logic       starve;
    logic [3:0] sys_starve;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_requester #(.DATA_W(8), .DEPTH(4), .STARVE_LIMIT(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .req          (req),
        .gnt          (gnt),
        .bus_valid    (bus_valid),
        .bus_data     (bus_data),
        .level        (level),
        .err_spurious (err_spurious)
`ifdef ARB_REQ_STARVE_MON_EN
       ,.starve       (starve)
`endif
    );

    logic       sys_iv, arb_en;
    logic [3:0] sys_req, sys_gnt, sys_in_ready, sys_bus_valid, sys_err;
    logic [7:0] sys_in_data  [NUM_REQ];
    logic [7:0] sys_bus_data [NUM_REQ];
    logic [2:0] sys_level    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sys
        arb_requester #(.DATA_W(8), .DEPTH(4), .STARVE_LIMIT(16)) u_sys (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (sys_iv),
            .in_ready     (sys_in_ready[g]),
            .in_data      (sys_in_data[g]),
            .req          (sys_req[g]),
            .gnt          (sys_gnt[g]),
            .bus_valid    (sys_bus_valid[g]),
            .bus_data     (sys_bus_data[g]),
            .level        (sys_level[g]),
            .err_spurious (sys_err[g])
`ifdef ARB_REQ_STARVE_MON_EN
           ,.starve       (sys_starve[g])
`endif
        );
    end

    function automatic logic [3:0] pick_p0(input logic [3:0] r);
        logic [3:0] g;
        g = '0;
        for (int p = NUM_REQ - 1; p >= 0; p--) if (r[p]) g = onehot_gnt(2'(p));
        return g;
    endfunction

    always_ff @(posedge clk) sys_gnt <= (rst || !arb_en) ? 4'b0 : pick_p0(sys_req);

    typedef struct {
        logic       rst, iv;
        logic [7:0] data;
        logic       gnt;
        logic       ir, rq, bv;
        logic [7:0] bd;
        logic [2:0] lv;
        logic       er;
    } vec_t;

    function automatic vec_t mk(input logic r, iv, input logic [7:0] d, input logic g,
                                input logic ir, rq, bv, input logic [7:0] bd,
                                input logic [2:0] lv, input logic er);
        vec_t v;
        v.rst = r; v.iv = iv; v.data = d; v.gnt = g;
        v.ir = ir; v.rq = rq; v.bv = bv; v.bd = bd; v.lv = lv; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    vec_t       vecs [30];
    logic [7:0] got [$];
    int         overlaps, nv;

    initial begin
        vecs[0]  = mk(0,1,8'hA5,0, 1,0,0,8'h00,0,0);
        vecs[1]  = mk(0,1,8'h3C,0, 1,1,0,8'h00,1,0);
        vecs[2]  = mk(0,1,8'h7E,0, 1,1,0,8'h00,2,0);
        vecs[3]  = mk(0,0,8'h00,0, 1,1,0,8'h00,3,0);
        vecs[4]  = mk(0,0,8'h00,1, 1,1,0,8'h00,3,0);
        vecs[5]  = mk(0,0,8'h00,1, 1,1,1,8'hA5,2,0);
        vecs[6]  = mk(0,0,8'h00,1, 1,0,1,8'h3C,1,0);
        vecs[7]  = mk(0,0,8'h00,0, 1,0,1,8'h7E,0,0);
        vecs[8]  = mk(0,0,8'h00,0, 1,0,0,8'h7E,0,0);
        vecs[9]  = mk(0,1,8'h11,0, 1,0,0,8'h7E,0,0);
        vecs[10] = mk(0,1,8'h22,0, 1,1,0,8'h7E,1,0);
        vecs[11] = mk(0,1,8'h33,0, 1,1,0,8'h7E,2,0);
        vecs[12] = mk(0,1,8'h44,0, 1,1,0,8'h7E,3,0);
        vecs[13] = mk(0,1,8'h55,0, 0,1,0,8'h7E,4,0);
        vecs[14] = mk(0,0,8'h00,1, 0,1,0,8'h7E,4,0);
        vecs[15] = mk(0,1,8'h66,1, 1,1,1,8'h11,3,0);
        vecs[16] = mk(0,0,8'h00,1, 1,1,1,8'h22,3,0);
        vecs[17] = mk(0,0,8'h00,1, 1,1,1,8'h33,2,0);
        vecs[18] = mk(0,0,8'h00,1, 1,0,1,8'h44,1,0);
        vecs[19] = mk(0,0,8'h00,0, 1,0,1,8'h66,0,0);
        vecs[20] = mk(0,0,8'h00,0, 1,0,0,8'h66,0,0);
        vecs[21] = mk(0,1,8'h9A,0, 1,0,0,8'h66,0,0);
        vecs[22] = mk(0,0,8'h00,1, 1,0,0,8'h66,1,0);
        vecs[23] = mk(0,0,8'h00,1, 1,0,1,8'h9A,0,0);
        vecs[24] = mk(0,0,8'h00,0, 1,0,0,8'h9A,0,1);
        vecs[25] = mk(0,1,8'h01,0, 1,0,0,8'h9A,0,1);
        vecs[26] = mk(0,1,8'h02,0, 1,1,0,8'h9A,1,1);
        vecs[27] = mk(1,0,8'h00,0, 1,1,0,8'h9A,2,1);
        vecs[28] = mk(0,0,8'h00,1, 1,0,0,8'h00,0,0);
        vecs[29] = mk(0,0,8'h00,0, 1,0,0,8'h00,0,1);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; gnt = 1'b0;
        sys_iv = 1'b0; arb_en = 1'b0;
        for (int p = 0; p < NUM_REQ; p++) sys_in_data[p] = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].data; gnt = vecs[i].gnt;
            @(negedge clk);
            chk("in_ready",  i, 8'(in_ready),     8'(vecs[i].ir));
            chk("req",       i, 8'(req),          8'(vecs[i].rq));
            chk("bus_valid", i, 8'(bus_valid),    8'(vecs[i].bv));
            chk("bus_data",  i, bus_data,         vecs[i].bd);
            chk("level",     i, 8'(level),        8'(vecs[i].lv));
            chk("err",       i, 8'(err_spurious), 8'(vecs[i].er));
        end

`ifdef ARB_REQ_STARVE_MON_EN
        @(posedge clk); #1; rst = 1'b1; in_valid = 1'b0; gnt = 1'b0;
        @(posedge clk); #1; rst = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        chk("starve_rst", 0, 8'(starve), 8'd0);
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("starve_15", 0, 8'(starve), 8'd0);
        @(posedge clk);
        @(negedge clk);
        chk("starve_16", 0, 8'(starve), 8'd1);
        gnt = 1'b1;
        @(posedge clk); #1; gnt = 1'b0;
        @(negedge clk);
        chk("starve_clr", 0, 8'(starve), 8'd0);
`endif

        @(posedge clk); #1; rst = 1'b1; in_valid = 1'b0; gnt = 1'b0;
        @(posedge clk); #1; rst = 1'b0; sys_iv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < NUM_REQ; p++) sys_in_data[p] = {p[3:0], k[3:0]};
            @(posedge clk); #1;
        end
        sys_iv = 1'b0; arb_en = 1'b1;
        overlaps = 0;
        for (int c = 0; c < 80 && got.size() < 12; c++) begin
            @(negedge clk);
            nv = 0;
            for (int p = 0; p < NUM_REQ; p++) if (sys_bus_valid[p]) begin
                nv++;
                got.push_back(sys_bus_data[p]);
            end
            if (nv > 1) overlaps++;
        end
        chk("sys_words", 0, 8'(got.size()), 8'd12);
        for (int i = 0; i < got.size() && i < 12; i++)
            chk("sys_order", i, got[i], 8'((i / 3) * 16 + (i % 3)));
        chk("sys_overlap", 0, 8'(overlaps), 8'd0);
        chk("sys_err", 0, 8'(sys_err), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
